video_capture: RTL and testbench

Captures a DVI-style parallel video input (hsync/vsync/active/RGB, the same signal set our scanout block drives) and converts it into an AXI4-Stream video stream for a VDMA S2MM channel. Frame start is marked with `tuser`, and line ends are marked with `tlast`. A line FIFO absorbs VDMA backpressure. The block also packs RGB565 two pixels per word, measures the incoming frame geometry, and drops whole frames cleanly on overflow.

---
 rtl/video_capture.sv | 205 ++++++++++++++++++++
 tb/tb_video_capture.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_capture.sv
// DVI parallel video capture into an AXI4-Stream video stream with a line FIFO,
// RGB565 two-pixel packing, frame geometry measurement and whole-frame drop on overflow.
module video_capture #(
    parameter int FIFO_DEPTH = 2048
) (
    input  logic        dvi_clk,
    input  logic        reset,
    input  logic        dvi_hsync,
    input  logic        dvi_vsync,
    input  logic        dvi_active_video,
    input  logic [31:0] dvi_rgb,
    input  logic        sync_polarity,
    input  logic        capture_enable,
    input  logic [2:0]  colormode,
    output logic [31:0] s_axis_vid_tdata,
    output logic        s_axis_vid_tvalid,
    input  logic        s_axis_vid_tready,
    output logic        s_axis_vid_tlast,
    output logic        s_axis_vid_tuser,
    output logic        overflow,
    output logic [15:0] frame_width,
    output logic [15:0] frame_height
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DROP} state_t;
    state_t state, state_nx;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Horizontal sync carries no information the capture path needs.
    logic hs, unused;
    assign hs     = dvi_hsync ^ sync_polarity;
    assign unused = ^{hs, dvi_rgb[31:24]};

    logic        vs_r, vs_d, act_h;
    logic [23:0] rgb_h;
    logic        vs_edge, line_end, cap;

    always_ff @(posedge dvi_clk) begin
        if (reset) begin
            vs_r  <= 1'b0;
            vs_d  <= 1'b0;
            act_h <= 1'b0;
            rgb_h <= '0;
        end else begin
            vs_r  <= dvi_vsync ^ sync_polarity;
            vs_d  <= vs_r;
            act_h <= dvi_active_video;
            rgb_h <= dvi_rgb[23:0];
        end
    end

    assign vs_edge  = vs_r & ~vs_d;
    assign line_end = act_h & ~dvi_active_video;
    assign cap      = act_h && (state == WAIT_SOF || state == CAPTURE);

    logic        cm16, half, tuser_pend, latch;
    logic [15:0] p0, p565;
    logic        wr_req;
    logic [31:0] wr_data;

    assign p565 = {rgb_h[23:19], rgb_h[15:10], rgb_h[7:3]};

    always_comb begin
        wr_req  = 1'b0;
        wr_data = '0;
        if (cap) begin
            if (!cm16) begin
                wr_req  = 1'b1;
                wr_data = {8'h00, rgb_h};
            end else if (half) begin
                wr_req  = 1'b1;
                wr_data = {p0[7:0], p0[15:8], p565[7:0], p565[15:8]};
            end else if (line_end) begin
                wr_req  = 1'b1;
                wr_data = {p565[7:0], p565[15:8], 16'h0000};
            end
        end
    end

    logic [AW:0] wr_ptr, rd_ptr, rd_nx, fill;
    logic        full, pop, wr_ok, ovf_ev;
    logic [33:0] mem [FIFO_DEPTH];

    assign pop    = s_axis_vid_tvalid & s_axis_vid_tready;
    assign fill   = wr_ptr - rd_ptr;
    assign full   = (fill == DEPTH_W);
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign wr_ok  = wr_req & (~full | pop);
    assign ovf_ev = wr_req & full & ~pop;
    assign rd_nx  = rd_ptr + {{AW{1'b0}}, pop};

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        case (state)
            IDLE: begin
                if (vs_edge && capture_enable) begin
                    state_nx = WAIT_SOF;
                    latch    = 1'b1;
                end
            end
            default: begin
                if (ovf_ev) begin
                    state_nx = DROP;
                end else if (vs_edge) begin
                    if (capture_enable) begin
                        state_nx = WAIT_SOF;
                        latch    = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (state == WAIT_SOF && cap) begin
                    state_nx = CAPTURE;
                end
            end
        endcase
    end

    always_ff @(posedge dvi_clk) begin
        if (reset) begin
            state      <= IDLE;
            cm16       <= 1'b0;
            half       <= 1'b0;
            p0         <= '0;
            tuser_pend <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nx;
            if (ovf_ev)
                overflow <= 1'b1;
            if (latch) begin
                cm16       <= (colormode == 3'd1);
                half       <= 1'b0;
                tuser_pend <= 1'b1;
            end else begin
                if (wr_ok)
                    tuser_pend <= 1'b0;
                if (cap && cm16) begin
                    if (half) begin
                        half <= 1'b0;
                    end else if (!line_end) begin
                        half <= 1'b1;
                        p0   <= p565;
                    end
                end
            end
        end
    end

    always_ff @(posedge dvi_clk) begin
        if (wr_ok)
            mem[wr_ptr[AW-1:0]] <= {tuser_pend, line_end, wr_data};
    end

    // Output register shows the FIFO head; it is only popped on a handshake.
    always_ff @(posedge dvi_clk) begin
        if (reset) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            s_axis_vid_tvalid <= 1'b0;
            s_axis_vid_tdata  <= '0;
            s_axis_vid_tlast  <= 1'b0;
            s_axis_vid_tuser  <= 1'b0;
        end else begin
            wr_ptr            <= wr_ptr + {{AW{1'b0}}, wr_ok};
            rd_ptr            <= rd_nx;
            s_axis_vid_tvalid <= (wr_ptr != rd_nx);
            if (wr_ptr != rd_nx)
                {s_axis_vid_tuser, s_axis_vid_tlast, s_axis_vid_tdata} <= mem[rd_nx[AW-1:0]];
        end
    end

    logic [15:0] pix_cnt, line_cnt, line_nx;
    assign line_nx = line_end ? sat_inc(line_cnt) : line_cnt;

    always_ff @(posedge dvi_clk) begin
        if (reset) begin
            pix_cnt      <= '0;
            line_cnt     <= '0;
            frame_width  <= '0;
            frame_height <= '0;
        end else begin
            if (act_h) begin
                if (line_end) begin
                    frame_width <= sat_inc(pix_cnt);
                    pix_cnt     <= '0;
                end else begin
                    pix_cnt <= sat_inc(pix_cnt);
                end
            end
            if (vs_edge) begin
                frame_height <= line_nx;
                line_cnt     <= '0;
            end else begin
                line_cnt <= line_nx;
            end
        end
    end

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: a frame-level model builds the expected word
// stream, and one negedge process checks every stream transfer against it.
module tb_video_capture;
    logic        dvi_clk = 1'b0;
    logic        reset;
    logic        dvi_hsync, dvi_vsync, dvi_active_video;
    logic [31:0] dvi_rgb;
    logic        sync_polarity, capture_enable;
    logic [2:0]  colormode;
    logic [31:0] s_axis_vid_tdata;
    logic        s_axis_vid_tvalid, s_axis_vid_tready, s_axis_vid_tlast, s_axis_vid_tuser;
    logic        overflow;
    logic [15:0] frame_width, frame_height;

    video_capture #(.FIFO_DEPTH(4)) dut (
        .dvi_clk(dvi_clk), .reset(reset), .dvi_hsync(dvi_hsync), .dvi_vsync(dvi_vsync),
        .dvi_active_video(dvi_active_video), .dvi_rgb(dvi_rgb), .sync_polarity(sync_polarity),
        .capture_enable(capture_enable), .colormode(colormode),
        .s_axis_vid_tdata(s_axis_vid_tdata), .s_axis_vid_tvalid(s_axis_vid_tvalid),
        .s_axis_vid_tready(s_axis_vid_tready), .s_axis_vid_tlast(s_axis_vid_tlast),
        .s_axis_vid_tuser(s_axis_vid_tuser), .overflow(overflow),
        .frame_width(frame_width), .frame_height(frame_height)
    );

    always #5 dvi_clk = ~dvi_clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, first_cyc = 0, tv_cnt = 0;
    bit lat_req = 0, lat_wait = 0;
    logic [31:0] pix_q[$], mp[$];
    logic [33:0] exp_q[$];

    always @(posedge dvi_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] to565(input logic [31:0] p);
        int r, g, b;
        r = int'(p[7:0]); g = int'(p[15:8]); b = int'(p[23:16]);
        return 16'((b / 8) * 2048 + (g / 4) * 32 + r / 8);
    endfunction

    function automatic logic [15:0] swap(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    // Expected words for a w x h frame; words past 'limit' are lost to overflow.
    task automatic model_frame(input int w, input int h, input bit m16, input int limit);
        int n = 0;
        bit first = 1;
        logic [31:0] a, d;
        logic [15:0] q1;
        bit last;
        for (int l = 0; l < h; l++) begin
            for (int x = 0; x < w; x += (m16 ? 2 : 1)) begin
                a = mp.pop_front();
                if (!m16) begin
                    d = a & 32'h00FF_FFFF;
                    last = (x == w - 1);
                end else begin
                    q1 = 16'h0000;
                    if (x + 1 < w) q1 = to565(mp.pop_front());
                    d = {swap(to565(a)), swap(q1)};
                    last = (x + 2 >= w);
                end
                if (n < limit) exp_q.push_back({first, last, d});
                first = 0;
                n++;
            end
        end
    endtask

    task automatic add_pix(input logic [31:0] p, input bit modelled);
        pix_q.push_back(p);
        if (modelled) mp.push_back(p);
    endtask

    task automatic tick();
        @(posedge dvi_clk);
        #1;
    endtask

    task automatic set_idle();
        dvi_active_video = 1'b0;
        dvi_rgb   = '0;
        dvi_vsync = sync_polarity;
        dvi_hsync = sync_polarity;
    endtask

    task automatic vsync_pulse();
        set_idle();
        dvi_vsync = ~sync_polarity;
        repeat (3) tick();
        set_idle();
        repeat (3) tick();
    endtask

    task automatic drive_lines(input int w, input int h);
        for (int l = 0; l < h; l++) begin
            for (int x = 0; x < w; x++) begin
                set_idle();
                dvi_active_video = 1'b1;
                dvi_rgb = pix_q.pop_front();
                if (lat_req) begin
                    first_cyc = cyc;
                    lat_req   = 0;
                    lat_wait  = 1;
                end
                tick();
            end
            set_idle();
            dvi_hsync = ~sync_polarity;
            repeat (2) tick();
            set_idle();
            repeat (2) tick();
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic frame_4x2_32(input string tag);
        for (int i = 1; i <= 8; i++) add_pix(i, 1);
        model_frame(4, 2, 0, 1000);
        vsync_pulse();
        drive_lines(4, 2);
        vsync_pulse();
        wait_drain();
        chk({tag, "_width"}, frame_width, 4);
        chk({tag, "_height"}, frame_height, 2);
    endtask

    logic        prev_v = 0, prev_r = 0;
    logic [33:0] prev_w = '0, cur, e;

    always @(negedge dvi_clk) begin
        cur = {s_axis_vid_tuser, s_axis_vid_tlast, s_axis_vid_tdata};
        if (reset) begin
            prev_v = 0;
        end else begin
            if (s_axis_vid_tvalid) tv_cnt++;
            if (lat_wait && s_axis_vid_tvalid) begin
                chk("latency_cycles", cyc - first_cyc, 3);
                lat_wait = 0;
            end
            if (prev_v && !prev_r) begin
                chk("hold_tvalid", s_axis_vid_tvalid, 1);
                chk("hold_word", cur, prev_w);
            end
            if (s_axis_vid_tvalid && s_axis_vid_tready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_word: got %h, expected no transfer", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_word", cur, e);
                end
            end
            prev_v = s_axis_vid_tvalid;
            prev_r = s_axis_vid_tready;
            prev_w = cur;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1; sync_polarity = 0; capture_enable = 1; colormode = 3'd2;
        s_axis_vid_tready = 1;
        set_idle();
        repeat (3) tick();
        chk("rst_tvalid", s_axis_vid_tvalid, 0);
        chk("rst_tlast", s_axis_vid_tlast, 0);
        chk("rst_tuser", s_axis_vid_tuser, 0);
        chk("rst_tdata", s_axis_vid_tdata, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_width", frame_width, 0);
        chk("rst_height", frame_height, 0);
        reset = 0;
        repeat (2) tick();

        // 32-bit 4x2 frame, also pins the model and first-word latency
        for (int i = 1; i <= 8; i++) add_pix(i, 1);
        model_frame(4, 2, 0, 1000);
        chk("model_size", exp_q.size(), 8);
        chk("model_first", exp_q[0], {1'b1, 1'b0, 32'h1});
        chk("model_eol", exp_q[3], {1'b0, 1'b1, 32'h4});
        lat_req = 1;
        vsync_pulse();
        drive_lines(4, 2);
        vsync_pulse();
        wait_drain();
        chk("s1_width", frame_width, 4);
        chk("s1_height", frame_height, 2);

        // 16-bit packing: F81F and 07E0 byte-swapped into one word
        colormode = 3'd1;
        add_pix(32'h00F8_00F8, 1);
        add_pix(32'h0000_FC00, 1);
        model_frame(2, 1, 1, 1000);
        chk("model_565", exp_q[0], {1'b1, 1'b1, 32'h1FF8_E007});
        vsync_pulse();
        drive_lines(2, 1);
        vsync_pulse();
        wait_drain();
        chk("s2_width", frame_width, 2);
        chk("s2_height", frame_height, 1);

        // odd width in 16-bit mode
        for (int i = 0; i < 6; i++) add_pix(32'h0010_2030 * (i + 1), 1);
        model_frame(3, 2, 1, 1000);
        chk("model_odd_size", exp_q.size(), 4);
        chk("model_odd_pad", {exp_q[1][32], exp_q[1][15:0]}, {1'b1, 16'h0000});
        vsync_pulse();
        drive_lines(3, 2);
        vsync_pulse();
        wait_drain();
        chk("s3_width", frame_width, 3);
        chk("s3_height", frame_height, 2);

        // overflow with tready held low, then clean resync on the next frame
        colormode = 3'd2;
        s_axis_vid_tready = 0;
        for (int i = 0; i < 64; i++) add_pix(32'h0100 + i, 1);
        model_frame(16, 4, 0, 4);
        vsync_pulse();
        drive_lines(16, 4);
        vsync_pulse();
        chk("ovf_flag", overflow, 1);
        chk("ovf_tvalid_held", s_axis_vid_tvalid, 1);
        chk("ovf_width", frame_width, 16);
        chk("ovf_height", frame_height, 4);
        s_axis_vid_tready = 1;
        wait_drain();
        for (int i = 1; i <= 8; i++) add_pix(32'h0200 + i, 1);
        model_frame(4, 2, 0, 1000);
        drive_lines(4, 2);
        vsync_pulse();
        wait_drain();
        chk("ovf_sticky", overflow, 1);

        // active-low syncs give the same result
        sync_polarity = 1;
        set_idle();
        repeat (2) tick();
        frame_4x2_32("pol");
        sync_polarity = 0;
        set_idle();
        repeat (2) tick();

        // capture disabled: geometry still measured, no stream output
        capture_enable = 0;
        tv_cnt = 0;
        for (int i = 0; i < 15; i++) add_pix(32'h0300 + i, 0);
        vsync_pulse();
        drive_lines(5, 3);
        vsync_pulse();
        repeat (4) tick();
        chk("dis_tvalid_count", tv_cnt, 0);
        chk("dis_width", frame_width, 5);
        chk("dis_height", frame_height, 3);

        // reset mid-line with the FIFO non-empty
        capture_enable = 1;
        s_axis_vid_tready = 0;
        vsync_pulse();
        for (int i = 0; i < 3; i++) begin
            dvi_active_video = 1; dvi_rgb = 32'h0400 + i;
            tick();
        end
        chk("pre_rst_tvalid", s_axis_vid_tvalid, 1);
        reset = 1; dvi_rgb = 32'h0403;
        tick();
        chk("mid_rst_tvalid", s_axis_vid_tvalid, 0);
        chk("mid_rst_overflow", overflow, 0);
        exp_q.delete();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            dvi_active_video = 1; dvi_rgb = 32'h0410 + i;
            tick();
        end
        set_idle();
        repeat (2) tick();
        for (int i = 0; i < 4; i++) add_pix(32'h0420 + i, 0);
        drive_lines(4, 1);
        s_axis_vid_tready = 1;
        tv_cnt = 0;
        repeat (10) tick();
        chk("post_rst_tvalid_count", tv_cnt, 0);
        frame_4x2_32("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
